// File: rtl/l2_tlb_refill_ctrl.sv
// l2_tlb_refill_ctrl
//    Fully-associative second-level TLB with a miss/refill controller that sits
//    between the L1 TLB miss port and the page-table walker.
//
//    A hit answers two cycles after accept. A miss issues one walk to the PTW.
//    On a valid PTE that was not killed by sfence, the controller fills a victim
//    entry with the PTE PPN and the write permission returned by the protection
//    stage.
//
// Ports
//    clk, reset           clock; synchronous active-high reset
//    req_*                lookup request (valid/ready) with VPN and store flag
//    resp_*               one-cycle registered response: ppn, store exception,
//                         page fault, sfence replay
//    ptw_req_*            walk request (valid/ready) carrying the latched VPN
//    ptw_resp_*           single-cycle walk result (pte valid bit, pte ppn)
//    prot_sel_vpn         protection-stage input select: 0 in S_WAIT, else 1
//    prot_vpn, prot_ppn   latched request VPN; pass-through of the PTE PPN
//    prot_w               same-cycle write permission from the protection stage
//    sfence_valid         flush all entries
//    perf_hits/misses     lookup hit/miss counters
//
// Configuration
//    L2_TLB_PERF_CNT_EN   when defined, perf_hits/perf_misses are live 32-bit
//                         counters; otherwise both are tied to zero.
module l2_tlb_refill_ctrl #(
   parameter int ENTRIES = 8,
   parameter int VPN_W   = 20,
   parameter int PPN_W   = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [VPN_W-1:0] req_vpn,
   input  logic             req_store,
   output logic             resp_valid,
   output logic [PPN_W-1:0] resp_ppn,
   output logic             resp_xcpt_st,
   output logic             resp_pf,
   output logic             resp_replay,
   output logic             ptw_req_valid,
   input  logic             ptw_req_ready,
   output logic [VPN_W-1:0] ptw_req_vpn,
   input  logic             ptw_resp_valid,
   input  logic             ptw_resp_pte_v,
   input  logic [PPN_W-1:0] ptw_resp_pte_ppn,
   output logic             prot_sel_vpn,
   output logic [VPN_W-1:0] prot_vpn,
   output logic [PPN_W-1:0] prot_ppn,
   input  logic             prot_w,
   input  logic             sfence_valid,
   output logic [31:0]      perf_hits,
   output logic [31:0]      perf_misses
);

   localparam int IDX_W = $clog2(ENTRIES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_PTW_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state_reg, state_next;

   // Entry storage. The tag compare is parallel over all entries, so the
   // arrays are held in flops rather than a RAM.
   logic [ENTRIES-1:0] valid_reg;
   logic [ENTRIES-1:0] w_reg;
   logic [VPN_W-1:0]   tag_reg [ENTRIES];
   logic [PPN_W-1:0]   ppn_reg [ENTRIES];
   logic [IDX_W-1:0]   rr_ptr_reg;

   logic               kill_reg;
   logic [VPN_W-1:0]   vpn_reg;
   logic               store_reg;

   logic               resp_valid_reg;
   logic [PPN_W-1:0]   resp_ppn_reg;
   logic               resp_xcpt_st_reg;
   logic               resp_pf_reg;
   logic               resp_replay_reg;
   logic               ptw_req_valid_reg;

   // Lookup / victim selection
   logic [ENTRIES-1:0] match;
   logic               hit;
   logic [PPN_W-1:0]   hit_ppn;
   logic               hit_w;
   logic [IDX_W-1:0]   victim_idx;

   // Output-process controls
   logic               accept;
   logic               fill_en;
   logic               resp_load;
   logic [PPN_W-1:0]   resp_ppn_next;
   logic               resp_xcpt_st_next;
   logic               resp_pf_next;
   logic               resp_replay_next;

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_match
         assign match[gi] = valid_reg[gi] && (tag_reg[gi] == vpn_reg);
      end
   endgenerate

   // Descending scans so that the lowest index has the final say, both for
   // a (theoretically impossible) multi-hit and for the first invalid slot.
   always_comb begin
      hit        = |match;
      hit_ppn    = '0;
      hit_w      = 1'b0;
      victim_idx = rr_ptr_reg;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_ppn = ppn_reg[i];
            hit_w   = w_reg[i];
         end
         if (!valid_reg[i]) begin
            victim_idx = IDX_W'(i);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (req_valid && !sfence_valid) state_next = S_LOOKUP;
         S_LOOKUP:  state_next = (sfence_valid || hit) ? S_RESP : S_PTW_REQ;
         S_PTW_REQ: if (ptw_req_ready) state_next = S_WAIT;
         S_WAIT:    if (ptw_resp_valid) state_next = S_RESP;
         S_RESP:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Output / datapath-control logic
   always_comb begin
      req_ready         = (state_reg == S_IDLE) && !sfence_valid;
      accept            = req_valid && (state_reg == S_IDLE) && !sfence_valid;
      prot_sel_vpn      = (state_reg != S_WAIT);
      prot_vpn          = vpn_reg;
      prot_ppn          = ptw_resp_pte_ppn;
      fill_en           = 1'b0;
      resp_load         = 1'b0;
      resp_ppn_next     = '0;
      resp_xcpt_st_next = 1'b0;
      resp_pf_next      = 1'b0;
      resp_replay_next  = 1'b0;
      case (state_reg)
         S_LOOKUP: begin
            if (sfence_valid) begin
               // Flush during lookup: answer with a replay, never walk.
               resp_load        = 1'b1;
               resp_replay_next = 1'b1;
            end else if (hit) begin
               resp_load         = 1'b1;
               resp_ppn_next     = hit_ppn;
               resp_xcpt_st_next = store_reg && !hit_w;
            end
         end
         S_WAIT: begin
            if (ptw_resp_valid) begin
               resp_load = 1'b1;
               // A flush in the same cycle as the result counts as a kill,
               // so the entry is never filled with a stale translation.
               if (kill_reg || sfence_valid) begin
                  resp_replay_next = 1'b1;
               end else if (ptw_resp_pte_v) begin
                  fill_en           = 1'b1;
                  resp_ppn_next     = ptw_resp_pte_ppn;
                  resp_xcpt_st_next = store_reg && !prot_w;
               end else begin
                  resp_pf_next = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Request latch, kill flag and registered responses
   always_ff @(posedge clk) begin
      if (reset) begin
         vpn_reg           <= '0;
         store_reg         <= 1'b0;
         kill_reg          <= 1'b0;
         resp_valid_reg    <= 1'b0;
         resp_ppn_reg      <= '0;
         resp_xcpt_st_reg  <= 1'b0;
         resp_pf_reg       <= 1'b0;
         resp_replay_reg   <= 1'b0;
         ptw_req_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            vpn_reg   <= req_vpn;
            store_reg <= req_store;
         end
         if (state_next == S_IDLE) begin
            kill_reg <= 1'b0;
         end else if (sfence_valid &&
                      (state_reg == S_PTW_REQ || state_reg == S_WAIT)) begin
            kill_reg <= 1'b1;
         end
         resp_valid_reg    <= (state_next == S_RESP);
         ptw_req_valid_reg <= (state_next == S_PTW_REQ);
         if (resp_load) begin
            resp_ppn_reg     <= resp_ppn_next;
            resp_xcpt_st_reg <= resp_xcpt_st_next;
            resp_pf_reg      <= resp_pf_next;
            resp_replay_reg  <= resp_replay_next;
         end
      end
   end

   // Valid bits and replacement pointer; a flush overrides a same-cycle fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg  <= '0;
         rr_ptr_reg <= '0;
      end else if (sfence_valid) begin
         valid_reg <= '0;
      end else if (fill_en) begin
         valid_reg[victim_idx] <= 1'b1;
         rr_ptr_reg            <= rr_ptr_reg + 1'b1;
      end
   end

   // Entry payload needs no reset; it is qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_reg[victim_idx] <= vpn_reg;
         ppn_reg[victim_idx] <= ptw_resp_pte_ppn;
         w_reg[victim_idx]   <= prot_w;
      end
   end

   assign resp_valid    = resp_valid_reg;
   assign resp_ppn      = resp_ppn_reg;
   assign resp_xcpt_st  = resp_xcpt_st_reg;
   assign resp_pf       = resp_pf_reg;
   assign resp_replay   = resp_replay_reg;
   assign ptw_req_valid = ptw_req_valid_reg;
   assign ptw_req_vpn   = vpn_reg;

`ifdef L2_TLB_PERF_CNT_EN
   logic        hit_evt;
   logic        miss_evt;
   logic [31:0] perf_hits_reg;
   logic [31:0] perf_misses_reg;

   assign hit_evt  = (state_reg == S_LOOKUP) && !sfence_valid && hit;
   assign miss_evt = (state_reg == S_LOOKUP) && !sfence_valid && !hit;

   // Counters survive sfence and wrap naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_hits_reg   <= '0;
         perf_misses_reg <= '0;
      end else begin
         if (hit_evt)  perf_hits_reg   <= perf_hits_reg + 32'd1;
         if (miss_evt) perf_misses_reg <= perf_misses_reg + 32'd1;
      end
   end

   assign perf_hits   = perf_hits_reg;
   assign perf_misses = perf_misses_reg;
`else
   assign perf_hits   = '0;
   assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_l2_tlb_refill_ctrl.sv
// Directed bench for l2_tlb_refill_ctrl: a table of lookup/walk vectors plus
// hand-written sequences for eviction, sfence, reset mid-walk and counters.
module tb_l2_tlb_refill_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [19:0] req_vpn;
   logic        req_store;
   logic        resp_valid;
   logic [19:0] resp_ppn;
   logic        resp_xcpt_st;
   logic        resp_pf;
   logic        resp_replay;
   logic        ptw_req_valid;
   logic        ptw_req_ready;
   logic [19:0] ptw_req_vpn;
   logic        ptw_resp_valid;
   logic        ptw_resp_pte_v;
   logic [19:0] ptw_resp_pte_ppn;
   logic        prot_sel_vpn;
   logic [19:0] prot_vpn;
   logic [19:0] prot_ppn;
   logic        prot_w;
   logic        sfence_valid;
   logic [31:0] perf_hits;
   logic [31:0] perf_misses;

   int n_vec = 0;
   int n_bad = 0;

`ifdef L2_TLB_PERF_CNT_EN
   localparam logic [31:0] EXP_HITS   = 32'd3;
   localparam logic [31:0] EXP_MISSES = 32'd2;
`else
   localparam logic [31:0] EXP_HITS   = 32'd0;
   localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

   l2_tlb_refill_ctrl #(.ENTRIES(8), .VPN_W(20), .PPN_W(20)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_vpn          (req_vpn),
      .req_store        (req_store),
      .resp_valid       (resp_valid),
      .resp_ppn         (resp_ppn),
      .resp_xcpt_st     (resp_xcpt_st),
      .resp_pf          (resp_pf),
      .resp_replay      (resp_replay),
      .ptw_req_valid    (ptw_req_valid),
      .ptw_req_ready    (ptw_req_ready),
      .ptw_req_vpn      (ptw_req_vpn),
      .ptw_resp_valid   (ptw_resp_valid),
      .ptw_resp_pte_v   (ptw_resp_pte_v),
      .ptw_resp_pte_ppn (ptw_resp_pte_ppn),
      .prot_sel_vpn     (prot_sel_vpn),
      .prot_vpn         (prot_vpn),
      .prot_ppn         (prot_ppn),
      .prot_w           (prot_w),
      .sfence_valid     (sfence_valid),
      .perf_hits        (perf_hits),
      .perf_misses      (perf_misses)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] vpn;
      logic        st;
      logic        pv;
      logic [19:0] pppn;
      logic        pw;
      logic        exp_walk;
      logic [19:0] exp_ppn;
      logic        exp_xcpt;
      logic        exp_pf;
   } vec_t;

   typedef struct {
      logic        walked;
      int          walk_cyc;
      logic [19:0] wvpn;
      logic        held;
      logic        psel;
      logic [19:0] pvpn;
      logic [19:0] pppn;
      logic        seen;
      int          resp_cyc;
      logic [19:0] ppn;
      logic        xcpt;
      logic        pf;
      logic        replay;
      logic        after;
   } res_t;

   vec_t vecs [9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // sf_mode: 0 none, 1 sfence in the lookup cycle, 2 sfence one cycle in S_WAIT.
   // Cycle numbers count edges after the accept edge (lookup cycle = 1).
   task automatic do_req(input logic [19:0] vpn, input logic st, input logic pv,
                         input logic [19:0] pppn, input logic pw, input int sf_mode,
                         output res_t r);
      int c;
      r.walked = 0; r.walk_cyc = 0; r.wvpn = '0; r.held = 0; r.psel = 1;
      r.pvpn = '0; r.pppn = '0; r.seen = 0; r.resp_cyc = 0; r.ppn = '0;
      r.xcpt = 0; r.pf = 0; r.replay = 0; r.after = 0;
      req_valid = 1'b1;
      req_vpn   = vpn;
      req_store = st;
      step();
      req_valid = 1'b0;
      c = 1;
      while (!r.seen && c < 60) begin
         if (resp_valid) begin
            r.seen     = 1;
            r.resp_cyc = c;
            r.ppn      = resp_ppn;
            r.xcpt     = resp_xcpt_st;
            r.pf       = resp_pf;
            r.replay   = resp_replay;
         end else if (ptw_req_valid && !r.walked) begin
            r.walked   = 1;
            r.walk_cyc = c;
            r.wvpn     = ptw_req_vpn;
            step(); c++;                      // PTW stalls one cycle
            r.held = ptw_req_valid;
            ptw_req_ready = 1'b1;
            step(); c++;
            ptw_req_ready = 1'b0;
            if (sf_mode == 2) begin
               sfence_valid = 1'b1;
               step(); c++;
               sfence_valid = 1'b0;
            end
            r.psel = prot_sel_vpn;
            r.pvpn = prot_vpn;
            ptw_resp_valid   = 1'b1;
            ptw_resp_pte_v   = pv;
            ptw_resp_pte_ppn = pppn;
            prot_w           = pw;
            #1;
            r.pppn = prot_ppn;
            step(); c++;
            ptw_resp_valid = 1'b0;
         end else begin
            if (sf_mode == 1 && c == 1) sfence_valid = 1'b1;
            step(); c++;
            sfence_valid = 1'b0;
         end
      end
      step();
      r.after = resp_valid;
   endtask

   task automatic check_resp(input string tag, input logic [19:0] vpn, input logic [19:0] pppn,
                             input res_t r, input logic exp_walk, input logic [19:0] exp_ppn,
                             input logic exp_xcpt, input logic exp_pf, input logic exp_replay,
                             input int exp_cyc);
      $display("txn %s vpn=%h walk=%0b cyc=%0d ppn=%h xcpt=%0b pf=%0b replay=%0b",
               tag, vpn, r.walked, r.resp_cyc, r.ppn, r.xcpt, r.pf, r.replay);
      chk({tag, " resp_seen"}, 32'(r.seen), 32'd1);
      chk({tag, " resp_cycle"}, r.resp_cyc, exp_cyc);
      chk({tag, " walked"}, 32'(r.walked), 32'(exp_walk));
      chk({tag, " replay"}, 32'(r.replay), 32'(exp_replay));
      chk({tag, " resp_pulse_len"}, 32'(r.after), 32'd0);
      if (!exp_replay) begin
         chk({tag, " ppn"}, 32'(r.ppn), 32'(exp_ppn));
         chk({tag, " xcpt_st"}, 32'(r.xcpt), 32'(exp_xcpt));
         chk({tag, " pf"}, 32'(r.pf), 32'(exp_pf));
      end
      if (exp_walk) begin
         chk({tag, " ptw_req_cycle"}, r.walk_cyc, 32'd2);
         chk({tag, " ptw_req_vpn"}, 32'(r.wvpn), 32'(vpn));
         chk({tag, " ptw_req_held"}, 32'(r.held), 32'd1);
         chk({tag, " prot_sel_vpn"}, 32'(r.psel), 32'd0);
         chk({tag, " prot_vpn"}, 32'(r.pvpn), 32'(vpn));
         chk({tag, " prot_ppn"}, 32'(r.pppn), 32'(pppn));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      reset = 1'b1; req_valid = 0; req_vpn = '0; req_store = 0;
      ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_pte_v = 0;
      ptw_resp_pte_ppn = '0; prot_w = 0; sfence_valid = 0;

      //          vpn       st  pv  pte_ppn   pw  walk  exp_ppn   xcpt pf
      vecs[0] = '{20'h00080, 0, 1, 20'h80000, 1,  1,   20'h80000, 0,  0};
      vecs[1] = '{20'h00080, 1, 0, 20'h00000, 0,  0,   20'h80000, 0,  0};
      vecs[2] = '{20'h00123, 1, 1, 20'h12345, 0,  1,   20'h12345, 1,  0};
      vecs[3] = '{20'h00123, 1, 0, 20'h00000, 0,  0,   20'h12345, 1,  0};
      vecs[4] = '{20'h00123, 0, 0, 20'h00000, 0,  0,   20'h12345, 0,  0};
      vecs[5] = '{20'h00777, 0, 0, 20'h55555, 1,  1,   20'h00000, 0,  1};
      vecs[6] = '{20'h00777, 0, 0, 20'h55555, 1,  1,   20'h00000, 0,  1};
      vecs[7] = '{20'h00777, 1, 1, 20'h77777, 1,  1,   20'h77777, 0,  0};
      vecs[8] = '{20'h00777, 1, 0, 20'h00000, 0,  0,   20'h77777, 0,  0};

      do_reset();

      // Reset state
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_ppn", 32'(resp_ppn), 32'd0);
      chk("rst resp_xcpt_st", 32'(resp_xcpt_st), 32'd0);
      chk("rst resp_pf", 32'(resp_pf), 32'd0);
      chk("rst resp_replay", 32'(resp_replay), 32'd0);
      chk("rst ptw_req_valid", 32'(ptw_req_valid), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst prot_sel_vpn", 32'(prot_sel_vpn), 32'd1);
      chk("rst perf_hits", perf_hits, 32'd0);
      chk("rst perf_misses", perf_misses, 32'd0);
      sfence_valid = 1'b1;
      #1;
      chk("rst req_ready_sfence", 32'(req_ready), 32'd0);
      sfence_valid = 1'b0;
      #1;

      // Table: fill, hit, write-permission exception, page fault
      for (int i = 0; i < 9; i++) begin
         do_req(vecs[i].vpn, vecs[i].st, vecs[i].pv, vecs[i].pppn, vecs[i].pw, 0, r);
         check_resp($sformatf("vec%0d", i), vecs[i].vpn, vecs[i].pppn, r, vecs[i].exp_walk,
                    vecs[i].exp_ppn, vecs[i].exp_xcpt, vecs[i].exp_pf, 1'b0,
                    vecs[i].exp_walk ? 5 : 2);
      end

      // Eviction: 9 fills into 8 entries; the 9th replaces entry 0
      do_reset();
      for (int i = 0; i < 9; i++) begin
         do_req(20'h00100 + 20'(i), 0, 1, 20'h00200 + 20'(i), 1, 0, r);
         check_resp($sformatf("fill%0d", i), 20'h00100 + 20'(i), 20'h00200 + 20'(i), r,
                    1'b1, 20'h00200 + 20'(i), 1'b0, 1'b0, 1'b0, 5);
      end
      do_req(20'h00108, 0, 0, 20'h0, 0, 0, r);
      check_resp("evict_hit9", 20'h00108, 20'h0, r, 1'b0, 20'h00208, 1'b0, 1'b0, 1'b0, 2);
      do_req(20'h00101, 0, 0, 20'h0, 0, 0, r);
      check_resp("evict_hit1", 20'h00101, 20'h0, r, 1'b0, 20'h00201, 1'b0, 1'b0, 1'b0, 2);
      do_req(20'h00100, 0, 1, 20'h00200, 1, 0, r);
      check_resp("evict_miss0", 20'h00100, 20'h00200, r, 1'b1, 20'h00200, 1'b0, 1'b0, 1'b0, 5);

      // sfence while waiting for the walk: replay, no fill, everything flushed
      do_req(20'h00300, 0, 1, 20'h00333, 1, 2, r);
      check_resp("sf_wait", 20'h00300, 20'h00333, r, 1'b1, 20'h0, 1'b0, 1'b0, 1'b1, 6);
      do_req(20'h00108, 0, 1, 20'h00208, 1, 0, r);
      check_resp("sf_flushed", 20'h00108, 20'h00208, r, 1'b1, 20'h00208, 1'b0, 1'b0, 1'b0, 5);
      do_req(20'h00300, 0, 1, 20'h00333, 1, 0, r);
      check_resp("sf_nofill", 20'h00300, 20'h00333, r, 1'b1, 20'h00333, 1'b0, 1'b0, 1'b0, 5);

      // sfence during lookup of a resident page: replay without a walk
      do_req(20'h00300, 0, 0, 20'h0, 0, 1, r);
      check_resp("sf_lookup", 20'h00300, 20'h0, r, 1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 2);
      do_req(20'h00300, 0, 1, 20'h00334, 1, 0, r);
      check_resp("sf_lookup_after", 20'h00300, 20'h00334, r, 1'b1, 20'h00334, 1'b0, 1'b0, 1'b0, 5);

      // Reset mid-walk, then a stray PTW response must be ignored
      req_valid = 1'b1; req_vpn = 20'h00500; req_store = 1'b0;
      step();
      req_valid = 1'b0;
      step();
      chk("midwalk ptw_req_valid", 32'(ptw_req_valid), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midwalk rst ptw_req_valid", 32'(ptw_req_valid), 32'd0);
      chk("midwalk rst req_ready", 32'(req_ready), 32'd1);
      ptw_resp_valid = 1'b1; ptw_resp_pte_v = 1'b1; ptw_resp_pte_ppn = 20'h0BAD0;
      step();
      ptw_resp_valid = 1'b0;
      chk("stray resp_valid", 32'(resp_valid), 32'd0);
      step();
      chk("stray resp_valid2", 32'(resp_valid), 32'd0);
      $display("txn midwalk_reset vpn=00500 ptw_req_valid=%0b resp_valid=%0b", ptw_req_valid, resp_valid);
      do_req(20'h00500, 0, 1, 20'h00555, 1, 0, r);
      check_resp("post_reset", 20'h00500, 20'h00555, r, 1'b1, 20'h00555, 1'b0, 1'b0, 1'b0, 5);

      // Performance counters: 2 misses + 3 hits
      do_reset();
      do_req(20'h00400, 0, 1, 20'h04000, 1, 0, r);
      do_req(20'h00401, 0, 1, 20'h04010, 1, 0, r);
      do_req(20'h00400, 0, 0, 20'h0, 0, 0, r);
      do_req(20'h00401, 0, 0, 20'h0, 0, 0, r);
      do_req(20'h00400, 0, 0, 20'h0, 0, 0, r);
      check_resp("perf_last", 20'h00400, 20'h0, r, 1'b0, 20'h04000, 1'b0, 1'b0, 1'b0, 2);
      $display("txn perf hits=%0d misses=%0d", perf_hits, perf_misses);
      chk("perf_hits", perf_hits, EXP_HITS);
      chk("perf_misses", perf_misses, EXP_MISSES);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/l2_tlb_refill_ctrl.md
# l2_tlb_refill_ctrl

Fully-associative second-level TLB array with a miss/refill controller, placed between the L1 TLB miss port and the page-table walker (PTW). It looks up the L1 miss VPN and returns the PPN on a hit. On a miss it issues a PTW request, hands the returned PTE PPN to the downstream address-protection stage, and fills an entry with the PPN and the returned write-permission bit. It also answers the original request with the PPN and a store-permission exception flag.

## Interface
Parameters:
- ENTRIES, 8: number of TLB entries (power of two, 2..32).
- VPN_W, 20: VPN width.
- PPN_W, 20: PPN width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous and active-high.
- req_valid  in  1  lookup request from L1 miss port.
- req_ready  out  1  request accepted when valid&ready.
- req_vpn  in  VPN_W  request VPN.
- req_store  in  1  request is a store.
- resp_valid  out  1  one-cycle response pulse; no back-pressure.
- resp_ppn  out  PPN_W  translated PPN.
- resp_xcpt_st  out  1  store to a non-writable page.
- resp_pf  out  1  PTE invalid (page fault).
- resp_replay  out  1  request killed by sfence; requester must retry.
- ptw_req_valid  out  1  walk request.
- ptw_req_ready  in  1  PTW accepts the walk.
- ptw_req_vpn  out  VPN_W  VPN to walk.
- ptw_resp_valid  in  1  single-cycle walk result.
- ptw_resp_pte_v  in  1  PTE valid bit.
- ptw_resp_pte_ppn  in  PPN_W  PTE PPN.
- prot_sel_vpn  out  1  select input to the protection stage: 0 in S_WAIT, 1 otherwise.
- prot_vpn  out  VPN_W  latched request VPN.
- prot_ppn  out  PPN_W  equals ptw_resp_pte_ppn (combinational).
- prot_w  in  1  write permission from the protection stage; same-cycle combinational.
- sfence_valid  in  1  flush all entries.
- perf_hits  out  32  hit counter.
- perf_misses  out  32  miss counter.

## Operation
- States: S_IDLE, S_LOOKUP, S_PTW_REQ, S_WAIT, S_RESP.
- Entry fields: valid, vpn tag, ppn, w.
- req_ready = (state==S_IDLE) & !sfence_valid. On accept, latch vpn/store and go to S_LOOKUP.
- S_LOOKUP compares all valid tags in parallel.
  - Hit: register ppn, xcpt_st = store & !w. Go to S_RESP.
  - Miss: go to S_PTW_REQ.
- Multiple tag matches cannot occur because fills only happen on a miss. If they do, the lowest index wins.
- S_PTW_REQ: ptw_req_valid=1, ptw_req_vpn=latched vpn. Go to S_WAIT on ptw_req_ready.
- S_WAIT: prot_sel_vpn=0. Wait for ptw_resp_valid.
  - pte_v=1 and not killed: fill the victim with {1, vpn, pte_ppn, prot_w}. Response ppn = pte_ppn, xcpt_st = store & !prot_w.
  - pte_v=0: no fill, resp_pf=1, ppn=0.
  - Either way, go to S_RESP.
- S_RESP: resp_valid=1 for exactly one cycle with the registered fields, then go to S_IDLE.
- Victim selection: the lowest-index invalid entry. If all entries are valid, use the round-robin pointer, which advances by one on every fill and wraps ENTRIES-1 to 0.
- sfence_valid clears all valid bits at the edge, in any state.
  - In S_LOOKUP it forces a miss-free replay response: resp_replay=1, no PTW request.
  - In S_PTW_REQ or S_WAIT it sets the kill flag. The walk still completes (ptw_req still handshakes), no fill occurs, and the response carries resp_replay=1.
  - If a fill and sfence_valid occur in the same cycle, the flush wins and the entry stays invalid.
  - The kill flag clears on entering S_IDLE.

## Timing
- Reset values:
  - state=S_IDLE.
  - All valid bits 0, round-robin pointer 0, kill flag 0.
  - resp_valid, resp_ppn, resp_xcpt_st, resp_pf, resp_replay = 0.
  - ptw_req_valid=0, perf counters=0.
  - req_ready=1 (unless sfence_valid is high).
- Hit latency: accept at cycle N, resp_valid at N+2.
- Miss latency: accept at N, ptw_req_valid from N+2, response 1 cycle after ptw_resp_valid.
- ptw_req_valid stays high until ptw_req_ready. ptw_resp_valid seen outside S_WAIT is ignored.
- Reset asserted mid-walk returns to the reset state next edge. A later stray ptw_resp is ignored.
- All response fields are registered. prot_ppn and prot_sel_vpn are the only combinational outputs besides req_ready.

## Configuration
- L2_TLB_PERF_CNT_EN defined:
  - perf_hits increments on each S_LOOKUP hit.
  - perf_misses increments on each S_LOOKUP miss.
  - Both are 32-bit, wrap 0xFFFFFFFF to 0, and are not cleared by sfence.
- Not defined: no counter registers; perf_hits and perf_misses are tied to 0.

## Test plan
- After reset, req vpn=0x00080 store=0, PTW returns pte_v=1 ppn=0x80000, prot_w=1 -> one ptw_req with vpn 0x00080; resp ppn=0x80000, xcpt_st=0; entry 0 filled.
- Repeat vpn=0x00080 store=1 -> no ptw_req; resp at accept+2 with ppn=0x80000, xcpt_st=0. Repeat with a page filled with prot_w=0 -> xcpt_st=1.
- Fill 9 distinct VPNs with ENTRIES=8 -> the 9th fill evicts entry 0 (pointer 0). A lookup of the first VPN misses again.
- PTW returns pte_v=0 -> resp_pf=1, ppn=0, no fill; the next identical request walks again.
- sfence_valid during S_WAIT, then ptw_resp pte_v=1 -> resp_replay=1, no fill, all entries invalid.
- With L2_TLB_PERF_CNT_EN: 3 hits + 2 misses -> perf_hits=3, perf_misses=2. Without the macro, both read 0.
